// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC sequencing, in-order memory requests and a small
// instruction buffer. Redirects flush the buffer and squash in-flight responses.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
  parameter int unsigned DEPTH        = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] Nop  = 32'h0000_0013;
  localparam logic [CntW:0] DepthC = (CntW + 1)'(DEPTH);

  logic [31:0]     pc_q, pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic [CntW-1:0] buffered_q, buffered_d;
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [31:0]     data_mem [DEPTH];
  logic [31:0]     pc_mem   [DEPTH];

  logic fire, rsp_ok, push, pop;
  logic [31:0] redirect_aligned;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Issue only when a buffer slot is reserved for the eventual response.
  assign imem_req_valid = reset_n && !redirect_valid &&
                          (({1'b0, outstanding_q} + {1'b0, buffered_q}) < DepthC);
  assign imem_req_addr  = pc_q;

  assign fire             = imem_req_valid && imem_req_ready;
  assign rsp_ok           = imem_rsp_valid && (outstanding_q != '0);
  assign inst_valid       = (buffered_q != '0);
  assign pop              = inst_valid && inst_ready && !redirect_valid;
  assign push             = rsp_ok && !redirect_valid && (drop_q == '0);
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};

  assign inst    = inst_valid ? data_mem[head_q] : Nop;
  assign inst_pc = inst_valid ? pc_mem[head_q]   : resp_pc_q;

  always_comb begin
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    buffered_d    = buffered_q;
    head_d        = head_q;
    tail_d        = tail_q;
    if (redirect_valid) begin
      // Everything still in flight belongs to the old path and must be dropped.
      pc_d          = redirect_aligned;
      resp_pc_d     = redirect_aligned;
      outstanding_d = outstanding_q - CntW'(rsp_ok);
      drop_d        = outstanding_q - CntW'(rsp_ok);
      buffered_d    = '0;
      head_d        = '0;
      tail_d        = '0;
    end else begin
      if (fire) begin
        pc_d = pc_q + 32'd4;
      end
      outstanding_d = outstanding_q + CntW'(fire) - CntW'(rsp_ok);
      if (rsp_ok && (drop_q != '0)) begin
        drop_d = drop_q - CntW'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        tail_d    = ptr_inc(tail_q);
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      buffered_d = buffered_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_q          <= RESET_VECTOR;
      resp_pc_q     <= RESET_VECTOR;
      outstanding_q <= '0;
      drop_q        <= '0;
      buffered_q    <= '0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      buffered_q    <= buffered_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n && push) begin
      data_mem[tail_q] <= imem_rsp_data;
      pc_mem[tail_q]   <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a 1-cycle memory model tags requests with a redirect
// epoch; surviving responses feed a scoreboard checked as decode consumes them.
module tb_fetch_unit;

  localparam logic [31:0] RV  = 32'h0040_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  logic        mem_en;
  logic        rsp_avail = 1'b0;
  logic [31:0] rsp_head = '0;

  int checks   = 0;
  int failures = 0;
  int pop_cnt  = 0;
  int epoch    = 0;
  logic [31:0] exp_req_addr = RV;

  typedef struct {logic [31:0] addr; int ep;} pend_t;
  typedef struct {logic [31:0] pc; logic [31:0] data;} exp_t;
  pend_t pend[$];
  exp_t  exp_q[$];

  fetch_unit #(.RESET_VECTOR(RV), .DEPTH(2)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready)
  );

  always #5 clock = ~clock;

  assign imem_rsp_valid = mem_en && rsp_avail;
  assign imem_rsp_data  = rsp_head;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor/scoreboard plus memory bookkeeping, all on the falling edge.
  always @(negedge clock) begin
    pend_t p;
    exp_t  e;
    if (reset_n && inst_valid && inst_ready) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_inst: actual pc=%h inst=%h required=none", inst_pc, inst);
      end else begin
        e = exp_q.pop_front();
        chk("sb_inst", inst, e.data);
        chk("sb_pc", inst_pc, e.pc);
      end
    end
    if (!reset_n) begin
      pend.delete();
      exp_q.delete();
      epoch++;
      exp_req_addr = RV;
    end else begin
      if (imem_rsp_valid && pend.size() > 0) begin
        p = pend.pop_front();
        if (!redirect_valid && p.ep == epoch) exp_q.push_back('{pc: p.addr, data: mem_data(p.addr)});
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_req_addr);
        chk("no_req_on_redirect", {31'd0, redirect_valid}, 32'd0);
        pend.push_back('{addr: imem_req_addr, ep: epoch});
        exp_req_addr = exp_req_addr + 32'd4;
      end
      if (redirect_valid) begin
        epoch++;
        exp_req_addr = {redirect_pc[31:2], 2'b00};
      end
    end
  end

  // Responses become visible the cycle after acceptance.
  always @(posedge clock) begin
    #1;
    rsp_avail = (pend.size() > 0);
    rsp_head  = rsp_avail ? mem_data(pend[0].addr) : 32'd0;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic ir, input logic me);
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready     = ir;
    mem_en         = me;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic wait_fire(input int n, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (imem_req_valid && imem_req_ready) begin
        ok = 1'b1;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL wait_fire: actual=timeout required=request");
  endtask

  task automatic wait_inst(input int n, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (inst_valid) begin
        ok = 1'b1;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL wait_inst: actual=timeout required=inst_valid");
  endtask

  initial begin
    logic        ok, found;
    int          n, snap;
    logic [31:0] held_inst, held_pc, a0;
    logic        held;

    reset_n = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1; mem_en = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) step();
    @(negedge clock);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, NOP);
    chk("rst_req_addr", imem_req_addr, RV);
    chk("rst_inst_pc", inst_pc, RV);

    // Stream with an always-ready memory and decoder.
    step();
    reset_n = 1'b1;
    @(negedge clock);
    chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, RV);
    repeat (10) step();
    snap = pop_cnt;
    repeat (30) step();
    chk("throughput", {31'd0, (pop_cnt - snap) >= 18}, 32'd1);

    // Decode stall: only DEPTH requests go out and the head holds.
    do_reset(1'b0, 1'b1);
    n = 0; held = 1'b0; held_inst = '0; held_pc = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (imem_req_valid && imem_req_ready) n++;
      if (inst_valid && held) begin
        chk("stall_inst_hold", inst, held_inst);
        chk("stall_pc_hold", inst_pc, held_pc);
      end
      if (inst_valid && !held) begin
        held = 1'b1; held_inst = inst; held_pc = inst_pc;
      end
      step();
    end
    @(negedge clock);
    chk("stall_req_count", n, 32'd2);
    chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("stall_head_pc", inst_pc, RV);
    step();
    inst_ready = 1'b1;
    repeat (20) step();

    // Redirect with two requests in flight; both responses must vanish.
    do_reset(1'b1, 1'b0);
    repeat (3) step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clock);
    chk("redir_req_gated", {31'd0, imem_req_valid}, 32'd0);
    step();
    redirect_valid = 1'b0; mem_en = 1'b1;
    @(negedge clock);
    chk("redir_req_addr", imem_req_addr, 32'h0000_0100);
    chk("redir_no_inst", {31'd0, inst_valid}, 32'd0);
    wait_inst(20, ok);
    if (ok) chk("redir_first_pc", inst_pc, 32'h0000_0100);
    repeat (10) step();

    // Redirect coinciding with a response and a pop.
    do_reset(1'b0, 1'b0);
    step(); step();
    mem_en = 1'b1;
    step();
    mem_en = 1'b0;
    inst_ready = 1'b1; mem_en = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
    @(negedge clock);
    chk("combo_inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("combo_inst_pc", inst_pc, RV);
    step();
    redirect_valid = 1'b0;
    @(negedge clock);
    chk("combo_no_inst", {31'd0, inst_valid}, 32'd0);
    chk("combo_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("combo_req_addr", imem_req_addr, 32'h0000_2000);
    wait_inst(20, ok);
    if (ok) chk("combo_first_pc", inst_pc, 32'h0000_2000);

    // Memory back-pressure, then reset mid-stream.
    repeat (10) step();
    imem_req_ready = 1'b0;
    step();
    @(negedge clock);
    a0 = imem_req_addr;
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clock);
      chk("bp_addr_hold", imem_req_addr, a0);
    end
    step();
    imem_req_ready = 1'b1;
    repeat (5) step();
    reset_n = 1'b0;
    step();
    @(negedge clock);
    chk("mid_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("mid_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("mid_rst_inst", inst, NOP);
    chk("mid_rst_req_addr", imem_req_addr, RV);
    chk("mid_rst_inst_pc", inst_pc, RV);
    step();
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("post_rst_req_addr", imem_req_addr, RV);

    // Back-to-back redirects: last one wins.
    repeat (5) step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3000;
    step();
    redirect_pc = 32'h0000_5002;
    step();
    redirect_valid = 1'b0;
    wait_inst(20, ok);
    if (ok) chk("b2b_first_pc", inst_pc, 32'h0000_5000);

    // PC wrap at the top of the address space.
    repeat (3) step();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wait_fire(20, ok);
      if (!ok) break;
      if (imem_req_addr == 32'hFFFF_FFFC) begin
        found = 1'b1;
        break;
      end
    end
    chk("wrap_seen", {31'd0, found}, 32'd1);
    if (found) begin
      wait_fire(20, ok);
      if (ok) chk("wrap_next_addr", imem_req_addr, 32'h0000_0000);
    end
    repeat (10) step();

    // Drain: stop requesting and confirm nothing was lost.
    imem_req_ready = 1'b0;
    repeat (8) step();
    @(negedge clock);
    chk("drain_sb_empty", exp_q.size(), 32'd0);
    chk("drain_no_inst", {31'd0, inst_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
